// File: rtl/systolic_pkg.sv
// Shared types for the systolic output collector: FSM state encoding and
// the row-pointer width helper used by the top level and the column lanes.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH,
    DONE
  } collector_state_t;

  // Pointers run 0..ROWS inclusive, so they need one bit beyond the row index.
  function automatic int unsigned ptr_width(input int unsigned rows);
    return $clog2(rows) + 1;
  endfunction

endpackage

// File: rtl/collector_col_lane.sv
// One result column: samples the skewed column stream once per SAMPLE_DIV
// clocks while valid and stores the words in a ROWS-deep column buffer.
module collector_col_lane
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned SAMPLE_DIV = 2,
  localparam int unsigned PW        = ptr_width(ROWS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  input  logic [WORD_SIZE-1:0]      data_i,
  input  logic                      clear_i,
  output logic [PW-1:0]             wp_o,
  output logic [PW-1:0]             wp_next_o,
  output logic [ROWS*WORD_SIZE-1:0] words_o,
  output logic                      drop_o
);

  localparam int unsigned PHW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned AW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [PW-1:0]        wp_q, wp_d;
  logic [PHW-1:0]       ph_q, ph_d;
  logic [WORD_SIZE-1:0] mem_q [ROWS];
  logic                 strobe, full;

  // Phase is zero on the first valid cycle, so a rising valid always samples.
  assign strobe = valid_i && (ph_q == '0) && !clear_i;
  assign full   = (wp_q == PW'(ROWS));
  assign drop_o = strobe && full;

  always_comb begin
    wp_d = wp_q;
    ph_d = '0;
    if (clear_i) begin
      wp_d = '0;
    end else begin
      if (strobe && !full) wp_d = wp_q + PW'(1);
      if (valid_i) ph_d = (ph_q == PHW'(SAMPLE_DIV - 1)) ? '0 : ph_q + PHW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      ph_q <= '0;
    end else begin
      wp_q <= wp_d;
      ph_q <= ph_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (strobe && !full) mem_q[wp_q[AW-1:0]] <= data_i;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_word
    assign words_o[r*WORD_SIZE +: WORD_SIZE] = mem_q[r];
  end

  assign wp_o      = wp_q;
  assign wp_next_o = wp_d;

endmodule

// File: rtl/systolic_output_collector.sv
// Deskews the skewed systolic column stream into row-aligned result rows and
// drains them over valid/ready. Optional COLLECTOR_PERF_CNT_EN adds perf_cycles.
module systolic_output_collector
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned SAMPLE_DIV = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [COLS*WORD_SIZE-1:0] matmul_output,
  input  logic [COLS-1:0]           output_col_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*WORD_SIZE-1:0] out_row,
  output logic [$clog2(ROWS):0]     out_row_idx,
  output logic                      done,
  output logic                      overflow
`ifdef COLLECTOR_PERF_CNT_EN
  ,
  output logic [31:0]               perf_cycles
`endif
);

  localparam int unsigned PW = ptr_width(ROWS);
  localparam int unsigned AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  collector_state_t           state_q, state_d;
  logic [PW-1:0]              wp         [COLS];
  logic [PW-1:0]              wp_next    [COLS];
  logic [ROWS*WORD_SIZE-1:0]  lane_words [COLS];
  logic [COLS-1:0]            drop;
  logic [ROWS-1:0]            complete_q, complete_d;
  logic [PW-1:0]              rp_q, rp_d;
  logic [AW-1:0]              ridx;
  logic                       overflow_q, all_full, accept, clear;

  assign clear = (state_q == DONE);

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    collector_col_lane #(
      .ROWS      (ROWS),
      .WORD_SIZE (WORD_SIZE),
      .SAMPLE_DIV(SAMPLE_DIV)
    ) u_lane (
      .clk_i    (clk),
      .rst_ni   (rst),
      .valid_i  (output_col_valid[c]),
      .data_i   (matmul_output[c*WORD_SIZE +: WORD_SIZE]),
      .clear_i  (clear),
      .wp_o     (wp[c]),
      .wp_next_o(wp_next[c]),
      .words_o  (lane_words[c]),
      .drop_o   (drop[c])
    );
  end

  // Completion is built from next-state pointers so the registered flag
  // appears exactly one cycle after the last column writes the row.
  always_comb begin
    complete_d = '0;
    all_full   = 1'b1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      complete_d[r] = 1'b1;
      for (int unsigned c = 0; c < COLS; c++) begin
        if (wp_next[c] <= PW'(r)) complete_d[r] = 1'b0;
      end
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      if (wp[c] != PW'(ROWS)) all_full = 1'b0;
    end
  end

  assign ridx      = rp_q[AW-1:0];
  assign out_valid = (rp_q < PW'(ROWS)) && complete_q[ridx];
  assign accept    = out_valid && out_ready;
  assign rp_d      = clear ? '0 : rp_q + PW'(accept);

  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        out_row[c*WORD_SIZE +: WORD_SIZE] = lane_words[c][32'(ridx)*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  assign out_row_idx = out_valid ? rp_q : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|output_col_valid) state_d = COLLECT;
      COLLECT: if (all_full) state_d = FLUSH;
      FLUSH:   if (rp_d == PW'(ROWS)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      complete_q <= '0;
      rp_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      complete_q <= complete_d;
      rp_q       <= rp_d;
      overflow_q <= overflow_q | (|drop);
    end
  end

  assign done     = (state_q == DONE);
  assign overflow = overflow_q;

`ifdef COLLECTOR_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (state_q == IDLE && (|output_col_valid)) begin
      perf_q <= 32'd1;
    end else if (state_q != IDLE) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_output_collector.sv
// Scoreboard bench for systolic_output_collector: a SAMPLE_DIV=2 and a
// SAMPLE_DIV=1 instance share stimulus, selected by sel.
module tb_systolic_output_collector;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 16;
  localparam int PW   = $clog2(ROWS) + 1;

  typedef struct {
    logic [COLS*W-1:0] row;
    logic [PW-1:0]     idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, rdy, sel;
  logic [COLS*W-1:0] mo;
  logic [COLS-1:0]   vld, vld_a, vld_b;
  logic              ov_a, ov_b, done_a, done_b, ovf_a, ovf_b;
  logic [COLS*W-1:0] row_a, row_b;
  logic [PW-1:0]     idx_a, idx_b;
  logic              ov, odone, ovf;
  logic [COLS*W-1:0] orow;
  logic [PW-1:0]     oidx;
`ifdef COLLECTOR_PERF_CNT_EN
  logic [31:0]       perf_a, perf_b, operf;
  assign operf = sel ? perf_b : perf_a;
`endif

  assign vld_a = sel ? '0 : vld;
  assign vld_b = sel ? vld : '0;
  assign ov    = sel ? ov_b : ov_a;
  assign orow  = sel ? row_b : row_a;
  assign oidx  = sel ? idx_b : idx_a;
  assign odone = sel ? done_b : done_a;
  assign ovf   = sel ? ovf_b : ovf_a;

  systolic_output_collector #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .SAMPLE_DIV(2)
  ) u_dut_div2 (
    .clk(clk), .rst(rst), .matmul_output(mo), .output_col_valid(vld_a),
    .out_valid(ov_a), .out_ready(rdy), .out_row(row_a), .out_row_idx(idx_a),
    .done(done_a), .overflow(ovf_a)
`ifdef COLLECTOR_PERF_CNT_EN
    , .perf_cycles(perf_a)
`endif
  );

  systolic_output_collector #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .SAMPLE_DIV(1)
  ) u_dut_div1 (
    .clk(clk), .rst(rst), .matmul_output(mo), .output_col_valid(vld_b),
    .out_valid(ov_b), .out_ready(rdy), .out_row(row_b), .out_row_idx(idx_b),
    .done(done_b), .overflow(ovf_b)
`ifdef COLLECTOR_PERF_CNT_EN
    , .perf_cycles(perf_b)
`endif
  );

  exp_t sb[$];
  int   cyc, base, salt, len0, sdiv;
  bit   stream_on;
  int   pass_cnt = 0;
  int   total    = 0;

  function automatic logic [W-1:0] word(input int s, input int r, input int c);
    return {s[7:0], r[3:0], c[3:0]};
  endfunction

  // Advance one clock; drive the skewed stream for the new cycle and queue
  // the expected row whenever the last column delivers its sample.
  task automatic cycle();
    logic [COLS*W-1:0] d;
    logic [COLS-1:0]   v;
    exp_t              e;
    @(posedge clk);
    #1;
    cyc++;
    d = '0;
    v = '0;
    if (stream_on) begin
      for (int c = 0; c < COLS; c++) begin
        int start, len, k, r;
        start = base + c * sdiv;
        len   = (c == 0) ? len0 : ROWS * sdiv;
        k     = cyc - start;
        if (k >= 0 && k < len) begin
          r = k / sdiv;
          v[c] = 1'b1;
          d[c*W +: W] = word(salt, r, c);
          if (c == COLS - 1 && k % sdiv == 0 && r < ROWS) begin
            for (int cc = 0; cc < COLS; cc++) e.row[cc*W +: W] = word(salt, r, cc);
            e.idx = PW'(r);
            sb.push_back(e);
          end
        end
      end
    end
    mo  = d;
    vld = v;
    #1;
  endtask

  task automatic do_reset();
    stream_on = 1'b0;
    mo  = '0;
    vld = '0;
    rdy = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ov !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov); else pass_cnt++;
    total++; if (orow !== '0) $display("FAIL reset_out_row: got %h want 0", orow); else pass_cnt++;
    total++; if (oidx !== '0) $display("FAIL reset_out_row_idx: got %0d want 0", oidx); else pass_cnt++;
    total++; if (odone !== 1'b0) $display("FAIL reset_done: got %b want 0", odone); else pass_cnt++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_overflow: got %b want 0", ovf); else pass_cnt++;
  endtask

  task automatic test_basic(input int div);
    exp_t        e;
    int          acc, dones, first_ov, done_cyc;
    logic [31:0] perf_at;
    sel = (div == 1);
    do_reset();
    sdiv = div; base = 10; salt = 0; len0 = ROWS * div; stream_on = 1'b1;
    acc = 0; dones = 0; first_ov = -1; done_cyc = -1; perf_at = '0;
    while (cyc < 80 && (done_cyc < 0 || cyc < done_cyc + 5)) begin
      cycle();
      rdy = 1'b1;
      if (ov && first_ov < 0) first_ov = cyc;
      if (ov && rdy) begin
        total++;
        if (sb.size() == 0) $display("FAIL basic%0d_row: got idx %0d want no row", div, oidx);
        else begin
          e = sb.pop_front();
          if (orow !== e.row || oidx !== e.idx)
            $display("FAIL basic%0d_row: got %h idx %0d want %h idx %0d", div, orow, oidx, e.row, e.idx);
          else pass_cnt++;
        end
        acc++;
      end
      if (odone) begin
        dones++; done_cyc = cyc;
        total++; if (acc !== ROWS) $display("FAIL basic%0d_done_early: got %0d accepts want %0d", div, acc, ROWS); else pass_cnt++;
      end
`ifdef COLLECTOR_PERF_CNT_EN
      if (done_cyc >= 0 && cyc == done_cyc + 1) perf_at = operf;
`endif
    end
    total++; if (first_ov !== base + (COLS - 1) * div + 1)
      $display("FAIL basic%0d_first_valid: got cycle %0d want %0d", div, first_ov, base + (COLS - 1) * div + 1); else pass_cnt++;
    total++; if (dones !== 1) $display("FAIL basic%0d_done_count: got %0d want 1", div, dones); else pass_cnt++;
    total++; if (acc !== ROWS) $display("FAIL basic%0d_accepts: got %0d want %0d", div, acc, ROWS); else pass_cnt++;
    total++; if (ovf !== 1'b0) $display("FAIL basic%0d_overflow: got %b want 0", div, ovf); else pass_cnt++;
`ifdef COLLECTOR_PERF_CNT_EN
    total++; if (perf_at !== 32'(done_cyc - base + 1))
      $display("FAIL basic%0d_perf: got %0d want %0d", div, perf_at, done_cyc - base + 1); else pass_cnt++;
    total++; if (operf !== perf_at) $display("FAIL basic%0d_perf_hold: got %0d want %0d", div, operf, perf_at); else pass_cnt++;
`endif
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t              e;
    int                acc, dones, done_cyc;
    bit                held;
    logic [COLS*W-1:0] held_row;
    logic [PW-1:0]     held_idx;
    do_reset();
    sdiv = 2; base = 10; salt = 8'h5A; len0 = ROWS * 2; stream_on = 1'b1;
    acc = 0; dones = 0; done_cyc = -1; held = 1'b0; held_row = '0; held_idx = '0;
    while (cyc < 100 && (done_cyc < 0 || cyc < done_cyc + 5)) begin
      cycle();
      rdy = (cyc <= 24) ? 1'b0 : (cyc % 2 == 1);
      if (held) begin
        total++;
        if (ov !== 1'b1 || orow !== held_row || oidx !== held_idx)
          $display("FAIL bp_hold: got v%b %h idx %0d want v1 %h idx %0d", ov, orow, oidx, held_row, held_idx);
        else pass_cnt++;
      end
      if (ov && rdy) begin
        total++;
        if (sb.size() == 0) $display("FAIL bp_row: got idx %0d want no row", oidx);
        else begin
          e = sb.pop_front();
          if (orow !== e.row || oidx !== e.idx)
            $display("FAIL bp_row: got %h idx %0d want %h idx %0d", orow, oidx, e.row, e.idx);
          else pass_cnt++;
        end
        acc++;
      end
      held = ov && !rdy; held_row = orow; held_idx = oidx;
      if (odone) begin
        dones++; done_cyc = cyc;
        total++; if (acc !== ROWS) $display("FAIL bp_done_early: got %0d accepts want %0d", acc, ROWS); else pass_cnt++;
      end
    end
    total++; if (acc !== ROWS) $display("FAIL bp_accepts: got %0d want %0d", acc, ROWS); else pass_cnt++;
    total++; if (dones !== 1) $display("FAIL bp_done_count: got %0d want 1", dones); else pass_cnt++;
    total++; if (ovf !== 1'b0) $display("FAIL bp_overflow: got %b want 0", ovf); else pass_cnt++;
  endtask

  task automatic test_overflow();
    exp_t e;
    int   acc, dones, done_cyc;
    do_reset();
    sdiv = 2; base = 10; salt = 8'h3C; len0 = 10; stream_on = 1'b1;
    acc = 0; dones = 0; done_cyc = -1;
    while (cyc < 80 && (done_cyc < 0 || cyc < done_cyc + 5)) begin
      cycle();
      rdy = 1'b1;
      if (cyc == 18) begin
        total++; if (ovf !== 1'b0) $display("FAIL ovf_before_fifth: got %b want 0", ovf); else pass_cnt++;
      end
      if (cyc == 19) begin
        total++; if (ovf !== 1'b1) $display("FAIL ovf_after_fifth: got %b want 1", ovf); else pass_cnt++;
      end
      if (ov && rdy) begin
        total++;
        if (sb.size() == 0) $display("FAIL ovf_row: got idx %0d want no row", oidx);
        else begin
          e = sb.pop_front();
          if (orow !== e.row || oidx !== e.idx)
            $display("FAIL ovf_row: got %h idx %0d want %h idx %0d", orow, oidx, e.row, e.idx);
          else pass_cnt++;
        end
        acc++;
      end
      if (odone) begin dones++; done_cyc = cyc; end
    end
    total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else pass_cnt++;
    total++; if (acc !== ROWS) $display("FAIL ovf_accepts: got %0d want %0d", acc, ROWS); else pass_cnt++;
    total++; if (dones !== 1) $display("FAIL ovf_done_count: got %0d want 1", dones); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   acc, dones, done_cyc;
    do_reset();
    sdiv = 2; base = 10; salt = 8'h11; len0 = ROWS * 2; stream_on = 1'b1;
    acc = 0; dones = 0; done_cyc = -1;
    while (cyc < 20) begin
      cycle();
      rdy = 1'b1;
      if (ov && rdy) begin
        total++;
        if (sb.size() == 0) $display("FAIL arst_pre_row: got idx %0d want no row", oidx);
        else begin
          e = sb.pop_front();
          if (orow !== e.row || oidx !== e.idx)
            $display("FAIL arst_pre_row: got %h idx %0d want %h idx %0d", orow, oidx, e.row, e.idx);
          else pass_cnt++;
        end
        acc++;
      end
      if (odone) dones++;
    end
    total++; if (acc !== 2) $display("FAIL arst_pre_accepts: got %0d want 2", acc); else pass_cnt++;
    #2;
    rst = 1'b0;
    stream_on = 1'b0;
    #1;
    total++; if (ov !== 1'b0) $display("FAIL arst_out_valid: got %b want 0", ov); else pass_cnt++;
    total++; if (orow !== '0) $display("FAIL arst_out_row: got %h want 0", orow); else pass_cnt++;
    total++; if (oidx !== '0) $display("FAIL arst_out_row_idx: got %0d want 0", oidx); else pass_cnt++;
    total++; if (odone !== 1'b0) $display("FAIL arst_done: got %b want 0", odone); else pass_cnt++;
    sb.delete();
    repeat (3) begin
      cycle();
      if (odone) dones++;
    end
    #3;
    rst = 1'b1;
    total++; if (dones !== 0) $display("FAIL arst_no_done: got %0d pulses want 0", dones); else pass_cnt++;
    cyc = 0; base = 10; salt = 8'h22; stream_on = 1'b1; acc = 0;
    while (cyc < 80 && (done_cyc < 0 || cyc < done_cyc + 5)) begin
      cycle();
      rdy = 1'b1;
      if (ov && rdy) begin
        total++;
        if (sb.size() == 0) $display("FAIL arst_post_row: got idx %0d want no row", oidx);
        else begin
          e = sb.pop_front();
          if (orow !== e.row || oidx !== e.idx)
            $display("FAIL arst_post_row: got %h idx %0d want %h idx %0d", orow, oidx, e.row, e.idx);
          else pass_cnt++;
        end
        acc++;
      end
      if (odone) begin dones++; done_cyc = cyc; end
    end
    total++; if (acc !== ROWS) $display("FAIL arst_post_accepts: got %0d want %0d", acc, ROWS); else pass_cnt++;
    total++; if (dones !== 1) $display("FAIL arst_post_done_count: got %0d want 1", dones); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   acc, dones, done_cyc;
    do_reset();
    sdiv = 2; base = 10; salt = 8'h01; len0 = ROWS * 2; stream_on = 1'b1;
    acc = 0; dones = 0; done_cyc = -1;
    while (cyc < 150 && (dones < 2 || cyc < done_cyc + 5)) begin
      cycle();
      rdy = 1'b1;
      if (ov && rdy) begin
        total++;
        if (sb.size() == 0) $display("FAIL b2b_row: got idx %0d want no row", oidx);
        else begin
          e = sb.pop_front();
          if (orow !== e.row || oidx !== e.idx)
            $display("FAIL b2b_row: got %h idx %0d want %h idx %0d", orow, oidx, e.row, e.idx);
          else pass_cnt++;
        end
        acc++;
      end
      if (odone) begin
        dones++; done_cyc = cyc;
        total++; if (acc !== ROWS * dones) $display("FAIL b2b_done_early: got %0d accepts want %0d", acc, ROWS * dones); else pass_cnt++;
        if (dones == 1) begin
          base = cyc + 2;
          salt = 8'h02;
        end
      end
    end
    total++; if (dones !== 2) $display("FAIL b2b_done_count: got %0d want 2", dones); else pass_cnt++;
    total++; if (acc !== 2 * ROWS) $display("FAIL b2b_accepts: got %0d want %0d", acc, 2 * ROWS); else pass_cnt++;
    total++; if (ovf !== 1'b0) $display("FAIL b2b_overflow: got %b want 0", ovf); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rdy = 1'b0; sel = 1'b0; mo = '0; vld = '0;
    stream_on = 1'b0; cyc = 0; base = 0; salt = 0; len0 = 0; sdiv = 2;
    test_reset();
    test_basic(2);
    test_backpressure();
    test_overflow();
    test_async_reset();
    test_back_to_back();
    test_basic(1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/systolic_output_collector.md
Name: systolic_output_collector

Overview:
- Downstream stage of the weight-stationary matmul FSM. Consumes the skewed column stream (matmul_output + output_col_valid).
- Column c's results arrive c matmul cycles after column 0. One matmul cycle is SAMPLE_DIV clk cycles.
- Deskews the stream into complete, row-aligned result rows (row r = all COLS results of output row r).
- Emits rows in order over a valid/ready handshake and pulses done after ROWS rows.

Parameters:
- ROWS, 4, result rows per matmul (= systolic rows).
- COLS, 4, columns per result row.
- WORD_SIZE, 16, bits per result element.
- SAMPLE_DIV, 2, clk cycles per matmul cycle; each column samples once per SAMPLE_DIV cycles while valid.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- matmul_output  in  COLS*WORD_SIZE  bottom_out of systolic; column c at [c*WORD_SIZE +: WORD_SIZE].
- output_col_valid  in  COLS  bit c high = column c of matmul_output carries valid data.
- out_valid  out  1  out_row holds a complete row.
- out_ready  in  1  consumer accepts row when out_valid && out_ready.
- out_row  out  COLS*WORD_SIZE  deskewed row, same column packing as input.
- out_row_idx  out  $clog2(ROWS)+1  index of row on out_row, 0..ROWS-1.
- done  out  1  one-cycle pulse after last row accepted.
- overflow  out  1  sticky; a sample arrived for a row still undrained.

Behaviour:
- Reset (rst low, async): state=IDLE; all pointers, phase counters and row_complete bits zeroed. Outputs out_valid=0, out_row=0, out_row_idx=0, done=0, overflow=0. Reset mid-operation discards all buffered rows; no done pulse.
- Storage: ROWS x COLS x WORD_SIZE buffer.
  - Per-column write pointer wp[c], 0..ROWS.
  - Per-column phase counter ph[c], 0..SAMPLE_DIV-1.
  - Read pointer rp, 0..ROWS.
- Sampling, per column c, every cycle:
  - If valid[c] && ph[c]==0: write word to buf[wp[c]][c]; wp[c]++.
  - If valid[c]: ph[c]=(ph[c]+1)%SAMPLE_DIV. If !valid[c]: ph[c]=0.
  - The first cycle valid[c] rises is always a sample.
- Row r is complete when wp[c]>r for all c. Complete is registered: visible on out_valid one cycle after the last column writes.
- Output: out_valid=1 while row rp is complete; out_row=buf[rp]; out_row_idx=rp.
  - On out_valid && out_ready: rp++. The next row may present the following cycle (back-to-back rows at full rate).
  - out_row is stable while out_valid && !out_ready.
- Capture and drain are concurrent. Capture never stalls, because the systolic cannot be backpressured.
- Overflow: a sample with wp[c]==ROWS is dropped; overflow=1 until reset.
- FSM:
  - IDLE: if any valid bit is high, go to COLLECT. The sample in that same cycle is captured.
  - COLLECT: when all wp[c]==ROWS, go to FLUSH.
  - FLUSH: when rp reaches ROWS via an accepted handshake, go to DONE.
  - DONE: done=1 for one cycle; clear wp, ph, rp, row_complete; go to IDLE.
- Simultaneous events:
  - Accept of row r and completion of row r+1 in the same cycle: out_valid stays high with row r+1 next cycle.
  - Valid asserted during DONE: sample is dropped; overflow is not set.
- Width rules: pointers are $clog2(ROWS)+1 bits and compare against ROWS exactly. No arithmetic on data; words pass through bit-exact.

Optional Feature:
- COLLECTOR_PERF_CNT_EN defined:
  - Adds output perf_cycles (32 bits).
  - Counts clk cycles from the IDLE->COLLECT transition through the DONE cycle inclusive.
  - Holds its value until the next IDLE->COLLECT, where it restarts at 1. Reset value 0.
- Not defined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package systolic_pkg holds:
  - collector_state_t enum {IDLE, COLLECT, FLUSH, DONE}.
  - Localparam function for pointer width ($clog2(ROWS)+1).
- One natural sub-module: collector_col_lane, instantiated per column. It holds wp[c], ph[c], the sample strobe and the column's ROWS-deep storage. The top level holds the row-complete AND tree, read pointer, handshake and FSM.

Test Plan:
- Basic 4x4, SAMPLE_DIV=2, out_ready=1:
  - Stimulus: column c valid for 8 clks starting at clk 10+2c, data = 16'h(r<<4|c).
  - Response: rows 0..3 out in order, row r word c = r<<4|c; first out_valid at clk 17; done pulses once after row 3.
- Backpressure: out_ready=0 until all capture ends, then toggle 1/0.
  - Response: exactly 4 accepted rows, each held stable while stalled; no overflow; done after 4th accept.
- Overflow: a 5th sample on column 0 (valid held 10 clks).
  - Response: overflow=1 and sticky; rows 0..3 still correct.
- Async reset (rst low) mid-COLLECT, after row 1 emitted.
  - Response: outputs zero immediately; no done.
  - A fresh matmul afterwards yields rows 0..3 correctly from row 0.
- Back-to-back matmuls: second stream starts 2 clks after done.
  - Response: two sets of rows 0..3, two done pulses, no overflow.
- SAMPLE_DIV=1 build: one sample per clk per column; same data checks as the first scenario.
  - With COLLECTOR_PERF_CNT_EN defined, perf_cycles is nonzero, stable after done, and equal to the cycle count from the first valid through the done cycle.
